// File: rtl/spi_seq_pkg.sv
// Shared constants for the SPI transfer sequencer: register map, CTRL/STATUS
// bit positions, sequencer state encoding and the reset transfer length.
package spi_seq_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int CTRL_NBITS_LSB = 0;
    localparam int CTRL_IRQ_EN    = 8;
    localparam int CTRL_FLUSH     = 9;

    localparam int STAT_TX_CNT_LSB = 0;
    localparam int STAT_RX_CNT_LSB = 8;
    localparam int STAT_BUSY       = 16;
    localparam int STAT_TX_FULL    = 17;
    localparam int STAT_RX_EMPTY   = 18;
    localparam int STAT_TX_OVF     = 24;
    localparam int STAT_RX_UDF     = 25;

    localparam logic [5:0] NBITS_RST = 6'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO with flush and a registered head word; one-cycle push-to-head.
// Push when full is dropped unless a pop lands in the same cycle; pop when empty is ignored.
module spi_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_in,
    input  logic             nrst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = head_q;

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            // A word arriving in the flush cycle survives as the sole entry.
            wr_ptr_d = push_i ? AW'(1) : '0;
            rd_ptr_d = '0;
            count_d  = push_i ? CW'(1) : '0;
            head_d   = push_i ? push_dat_i : head_q;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
            if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = push_dat_i;
            else                                   head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_in) begin
        if (flush_i && push_i)  mem_q[0]        <= push_dat_i;
        else if (push_ok)       mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/spi_seq.sv
// SPI transfer sequencer: bus registers, TX/RX FIFOs and a 4-state engine handshake.
// Read data one cycle after bus_rd; transfers wait while TX is empty or RX has no room.
module spi_seq
    import spi_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        nrst,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic [31:0] eng_mosi_data,
    output logic [5:0]  eng_nbits,
    output logic        eng_request,
    input  logic [31:0] eng_miso_data,
    input  logic        eng_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_e  state_q, state_d;
    logic [5:0]  nbits_q, nbits_d;
    logic        irq_en_q, irq_en_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_udf_q, rx_udf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;
    logic [31:0] mosi_q, mosi_d;
    logic [5:0]  eng_nbits_q, eng_nbits_d;
    logic        req_q, req_d;

    logic          wr_data, wr_ctrl, wr_stat, rd_data, flush;
    logic          tx_pop, rx_push, start;
    logic          tx_full, tx_empty, rx_full, rx_empty, rx_empty_nxt;
    logic [CW-1:0] tx_count, rx_count;
    logic [31:0]   tx_head, rx_head, ctrl_word, status_word;

    assign wr_data = bus_wr && (bus_addr == ADDR_DATA);
    assign wr_ctrl = bus_wr && (bus_addr == ADDR_CTRL);
    assign wr_stat = bus_wr && (bus_addr == ADDR_STATUS);
    assign rd_data = bus_rd && (bus_addr == ADDR_DATA);
    assign flush   = wr_ctrl && bus_wdata[CTRL_FLUSH];

    assign start   = (state_q == S_IDLE) && !tx_empty && (rx_count < CW'(FIFO_DEPTH));
    assign tx_pop  = start;
    assign rx_push = (state_q == S_DONE) && eng_ready;

    spi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk_in     (clk_in),
        .nrst       (nrst),
        .push_i     (wr_data),
        .push_dat_i (bus_wdata),
        .pop_i      (tx_pop),
        .flush_i    (flush),
        .full_o     (tx_full),
        .empty_o    (tx_empty),
        .count_o    (tx_count),
        .head_o     (tx_head)
    );

    spi_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rx_fifo (
        .clk_in     (clk_in),
        .nrst       (nrst),
        .push_i     (rx_push),
        .push_dat_i (eng_miso_data),
        .pop_i      (rd_data),
        .flush_i    (flush),
        .full_o     (rx_full),
        .empty_o    (rx_empty),
        .count_o    (rx_count),
        .head_o     (rx_head)
    );

    // RX always has room for a completing transfer, since a start requires a free slot.
    always_comb begin
        if (rx_push)    rx_empty_nxt = 1'b0;
        else if (flush) rx_empty_nxt = 1'b1;
        else            rx_empty_nxt = rx_empty || ((rx_count == CW'(1)) && rd_data);
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_NBITS_LSB +: 6] = nbits_q;
        ctrl_word[CTRL_IRQ_EN]         = irq_en_q;

        status_word = '0;
        status_word[STAT_TX_CNT_LSB +: 5] = 5'(tx_count);
        status_word[STAT_RX_CNT_LSB +: 5] = 5'(rx_count);
        status_word[STAT_BUSY]            = (state_q != S_IDLE);
        status_word[STAT_TX_FULL]         = tx_full;
        status_word[STAT_RX_EMPTY]        = rx_empty;
        status_word[STAT_TX_OVF]          = tx_ovf_q;
        status_word[STAT_RX_UDF]          = rx_udf_q;
    end

    always_comb begin
        nbits_d  = wr_ctrl ? bus_wdata[CTRL_NBITS_LSB +: 6] : nbits_q;
        irq_en_d = wr_ctrl ? bus_wdata[CTRL_IRQ_EN] : irq_en_q;

        // New error events win over a same-cycle write-one-to-clear.
        tx_ovf_d = (tx_ovf_q && !(wr_stat && bus_wdata[STAT_TX_OVF]))
                 || (wr_data && tx_full && !tx_pop);
        rx_udf_d = (rx_udf_q && !(wr_stat && bus_wdata[STAT_RX_UDF]))
                 || (rd_data && rx_empty);

        irq_d = irq_en_d && !rx_empty_nxt;

        rdata_d = rdata_q;
        if (bus_rd) begin
            case (bus_addr)
                ADDR_DATA:   rdata_d = rx_empty ? 32'd0 : rx_head;
                ADDR_CTRL:   rdata_d = ctrl_word;
                ADDR_STATUS: rdata_d = status_word;
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        mosi_d      = mosi_q;
        eng_nbits_d = eng_nbits_q;
        req_d       = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d     = S_REQ;
                mosi_d      = tx_head;
                eng_nbits_d = nbits_q;
                req_d       = 1'b1;
            end
            S_REQ:  state_d = S_ACK;
            S_ACK:  if (!eng_ready) state_d = S_DONE;
            S_DONE: if (eng_ready)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            nbits_q     <= NBITS_RST;
            irq_en_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            rx_udf_q    <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
            mosi_q      <= '0;
            eng_nbits_q <= NBITS_RST;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nbits_q     <= nbits_d;
            irq_en_q    <= irq_en_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_udf_q    <= rx_udf_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            mosi_q      <= mosi_d;
            eng_nbits_q <= eng_nbits_d;
            req_q       <= req_d;
        end
    end

    assign bus_rdata     = rdata_q;
    assign irq           = irq_q;
    assign eng_mosi_data = mosi_q;
    assign eng_nbits     = eng_nbits_q;
    assign eng_request   = req_q;

endmodule

// File: tb/tb_spi_seq.sv
// Directed bench for spi_seq with a behavioural SPI engine that returns the
// inverted request word masked to nbits+1 bits, three cycles after the request.
module tb_spi_seq;

    logic        clk_in = 1'b0;
    logic        nrst = 1'b0;
    logic        bus_wr = 1'b0;
    logic        bus_rd = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        irq;
    logic [31:0] eng_mosi_data;
    logic [5:0]  eng_nbits;
    logic        eng_request;
    logic [31:0] eng_miso_data = 32'd0;
    logic        eng_ready = 1'b1;

    int          errors = 0;
    int          checks = 0;
    int          req_count = 0;
    int          eng_cnt = 0;
    logic        stall = 1'b0;
    logic [5:0]  seen_nbits = 6'd0;
    logic [31:0] seen_mosi = 32'd0;
    logic [31:0] pending = 32'd0;

    spi_seq #(.FIFO_DEPTH(4)) dut (
        .clk_in        (clk_in),
        .nrst          (nrst),
        .bus_wr        (bus_wr),
        .bus_rd        (bus_rd),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .irq           (irq),
        .eng_mosi_data (eng_mosi_data),
        .eng_nbits     (eng_nbits),
        .eng_request   (eng_request),
        .eng_miso_data (eng_miso_data),
        .eng_ready     (eng_ready)
    );

    initial forever #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] nmask(input logic [5:0] n);
        if (n == 6'd31) return 32'hFFFF_FFFF;
        return (32'd1 << (n + 6'd1)) - 32'd1;
    endfunction

    // Behavioural engine: drops ready on request, raises it with the result later.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!nrst) begin
                eng_ready = 1'b1;
                eng_cnt   = 0;
            end else if (eng_request) begin
                req_count++;
                seen_nbits = eng_nbits;
                seen_mosi  = eng_mosi_data;
                pending    = ~eng_mosi_data & nmask(eng_nbits);
                eng_ready  = 1'b0;
                eng_cnt    = 3;
            end else if (eng_cnt > 0 && !stall) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_miso_data = pending;
                    eng_ready     = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_in);
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = 1'b1;
        @(negedge clk_in);
        bus_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_in);
        bus_addr = a;
        bus_rd   = 1'b1;
        @(negedge clk_in);
        bus_rd   = 1'b0;
        d        = bus_rdata;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        bit          done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            bus_read(2'd2, st);
            if (!st[16] && st[4:0] == 5'd0) done = 1'b1;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_ready(input logic lvl, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk_in);
            #1;
            if (eng_ready === lvl) ok = 1'b1;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int base;

        // Reset values held while nrst is low
        tick(3);
        #1;
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_req", {31'd0, eng_request}, 32'd0);
        check("rst_mosi", eng_mosi_data, 32'd0);
        check("rst_nbits", {26'd0, eng_nbits}, 32'd7);
        nrst = 1'b1;
        tick(2);
        read_check("rst_ctrl", 2'd1, 32'h0000_0007);
        read_check("rst_status", 2'd2, 32'h0004_0000);
        read_check("reserved_rd", 2'd3, 32'd0);

        // Single transfer
        bus_write(2'd1, 32'h0000_0007);
        bus_write(2'd0, 32'h0000_00A5);
        wait_idle("single_idle");
        check("single_reqs", req_count, 32'd1);
        check("single_eng_nbits", {26'd0, seen_nbits}, 32'd7);
        check("single_eng_mosi", seen_mosi, 32'h0000_00A5);
        read_check("single_status", 2'd2, 32'h0000_0100);
        read_check("single_rx", 2'd0, 32'h0000_005A);
        read_check("single_status2", 2'd2, 32'h0004_0000);

        // Underflow and W1C
        read_check("udf_data", 2'd0, 32'd0);
        read_check("udf_status", 2'd2, 32'h0204_0000);
        bus_write(2'd2, 32'h0200_0000);
        read_check("udf_cleared", 2'd2, 32'h0004_0000);

        // Stream and overflow with a stalled engine
        base  = req_count;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h11 + i);
        tick(5);
        read_check("stream_full", 2'd2, 32'h0007_0004);
        check("stream_inflight", req_count - base, 32'd1);
        bus_write(2'd0, 32'h0000_0016);
        read_check("stream_ovf", 2'd2, 32'h0107_0004);
        stall = 1'b0;
        tick(80);
        read_check("stream_rx_full", 2'd2, 32'h0100_0401);
        check("stream_reqs4", req_count - base, 32'd4);
        read_check("stream_rx0", 2'd0, 32'h0000_00EE);
        tick(30);
        read_check("stream_5th_done", 2'd2, 32'h0100_0400);
        read_check("stream_rx1", 2'd0, 32'h0000_00ED);
        read_check("stream_rx2", 2'd0, 32'h0000_00EC);
        read_check("stream_rx3", 2'd0, 32'h0000_00EB);
        read_check("stream_rx4", 2'd0, 32'h0000_00EA);
        read_check("stream_end", 2'd2, 32'h0104_0000);
        bus_write(2'd2, 32'h0100_0000);
        read_check("ovf_cleared", 2'd2, 32'h0004_0000);

        // nbits change while a transfer is in flight
        bus_write(2'd1, 32'h0000_001F);
        stall = 1'b1;
        bus_write(2'd0, 32'h0000_1234);
        tick(5);
        check("mid_nbits_a", {26'd0, eng_nbits}, 32'd31);
        bus_write(2'd1, 32'h0000_000F);
        tick(2);
        check("mid_nbits_b", {26'd0, eng_nbits}, 32'd31);
        check("mid_mosi", eng_mosi_data, 32'h0000_1234);
        read_check("mid_ctrl", 2'd1, 32'h0000_000F);
        bus_write(2'd0, 32'h0000_5678);
        stall = 1'b0;
        wait_idle("mid_idle");
        check("mid_next_nbits", {26'd0, seen_nbits}, 32'd15);
        check("mid_next_mosi", seen_mosi, 32'h0000_5678);
        read_check("mid_rx0", 2'd0, 32'hFFFF_EDCB);
        read_check("mid_rx1", 2'd0, 32'h0000_A987);

        // Flush with a transfer in flight
        bus_write(2'd1, 32'h0000_0007);
        stall = 1'b1;
        bus_write(2'd0, 32'h0000_0001);
        bus_write(2'd0, 32'h0000_0002);
        bus_write(2'd0, 32'h0000_0003);
        tick(3);
        read_check("flush_pre", 2'd2, 32'h0005_0002);
        bus_write(2'd1, 32'h0000_0207);
        read_check("flush_post", 2'd2, 32'h0005_0000);
        read_check("flush_ctrl", 2'd1, 32'h0000_0007);
        stall = 1'b0;
        tick(20);
        read_check("flush_result", 2'd2, 32'h0000_0100);
        read_check("flush_rx", 2'd0, 32'h0000_00FE);

        // Reset while the sequencer waits in DONE
        base = req_count;
        bus_write(2'd1, 32'h0000_0113);
        stall = 1'b1;
        bus_write(2'd0, 32'h0000_0077);
        bus_write(2'd0, 32'h0000_0078);
        tick(6);
        check("rd_inflight", req_count - base, 32'd1);
        check("rd_ready_low", {31'd0, eng_ready}, 32'd0);
        check("rd_nbits19", {26'd0, eng_nbits}, 32'd19);
        read_check("rd_ctrl", 2'd1, 32'h0000_0113);
        @(negedge clk_in);
        nrst = 1'b0;
        tick(2);
        #1;
        check("rd_rst_req", {31'd0, eng_request}, 32'd0);
        check("rd_rst_nbits", {26'd0, eng_nbits}, 32'd7);
        check("rd_rst_mosi", eng_mosi_data, 32'd0);
        check("rd_rst_rdata", bus_rdata, 32'd0);
        nrst  = 1'b1;
        stall = 1'b0;
        tick(20);
        read_check("rd_status", 2'd2, 32'h0004_0000);
        check("rd_no_new_req", req_count - base, 32'd1);
        read_check("rd_ctrl_rst", 2'd1, 32'h0000_0007);

        // Interrupt timing
        bus_write(2'd1, 32'h0000_0107);
        tick(1);
        check("irq_idle", {31'd0, irq}, 32'd0);
        bus_write(2'd0, 32'h0000_003C);
        wait_ready(1'b0, "irq_ready_low");
        wait_ready(1'b1, "irq_ready_high");
        check("irq_before_push", {31'd0, irq}, 32'd0);
        @(negedge clk_in);
        #1;
        check("irq_after_push", {31'd0, irq}, 32'd1);
        read_check("irq_rx", 2'd0, 32'h0000_00C3);
        check("irq_after_pop", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
